// File: rtl/pulse_slot_arbiter.sv
// pulse_slot_arbiter
//   Shares one loadable down-counting pulse timer between N requesters.
//   Round-robin arbitration picks a winner, loads the counter with that
//   requester's length and drives the shared pulse for exactly that many
//   cycles, then strobes done to the winner for one cycle.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous reset, active-high
//   req     [N]    per-requester request level, held until its done
//   len     [N*W]  per-requester pulse length, slice i = len[i*W +: W]
//   cancel  aborts the pulse in progress (RUN only)
//   grant   [N]    one-hot requester being served, zero when idle
//   pulse   shared timer output, high while the counter runs
//   done    [N]    one-cycle completion strobe to the served requester
//   busy    high whenever not idle
module pulse_slot_arbiter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] len,
  input  logic           cancel,
  output logic [N-1:0]   grant,
  output logic           pulse,
  output logic [N-1:0]   done,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  win_q, win_d;
  logic [N-1:0]   grant_q, grant_d;

  // Per-requester length view
  logic [N-1:0][W-1:0] len_a;

  for (genvar i = 0; i < N; i++) begin : g_len
    assign len_a[i] = len[i*W +: W];
  end

  // Round-robin scan: first set request starting at ptr, wrapping mod N.
  logic          found;
  logic [PW-1:0] win_idx;
  logic [PW:0]   scan_idx;

  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (scan_idx >= (PW+1)'(N)) scan_idx = scan_idx - (PW+1)'(N);
      if (!found && req[scan_idx[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = scan_idx[PW-1:0];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          win_d            = win_idx;
          cnt_d            = len_a[win_idx];
          // A zero-length request skips RUN entirely so no pulse is emitted
          state_d          = (len_a[win_idx] == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // cnt is always >= 1 in RUN, so the decrement cannot wrap
        cnt_d = cnt_q - 1'b1;
        if (cancel || cnt_q == W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        // Winner drops to lowest priority for the next round
        ptr_d   = (win_q == PW'(N-1)) ? '0 : win_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
    end
  end

  // Outputs come only from registers / state decode
  assign grant = grant_q;
  assign pulse = (state_q == S_RUN);
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE) ? grant_q : '0;

endmodule
